// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL opcodes, channel structs and response-entry type
package tlul_pkg;

  localparam int DataW = 32;
  localparam int SrcW  = 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic             a_valid;
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [1:0]       a_size;
    logic [SrcW-1:0]  a_source;
    logic [31:0]      a_address;
    logic [3:0]       a_mask;
    logic [DataW-1:0] a_data;
    logic             d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic             d_valid;
    logic [2:0]       d_opcode;
    logic [2:0]       d_param;
    logic [1:0]       d_size;
    logic [SrcW-1:0]  d_source;
    logic             d_sink;
    logic [DataW-1:0] d_data;
    logic             d_error;
    logic             a_ready;
  } tl_d2h_t;

  // One queued D-channel response
  typedef struct packed {
    logic [2:0]       opcode;
    logic [1:0]       size;
    logic [SrcW-1:0]  source;
    logic             error;
    logic [DataW-1:0] data;
  } tl_rsp_t;

  // Byte lanes covered by an access of 2^size bytes at byte offset lo
  function automatic logic [3:0] size_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    size_mask = 4'b0001 << lo;
      2'd1:    size_mask = 4'b0011 << lo;
      default: size_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - synchronous FIFO with occupancy count, push may coincide with pop
module fifo_sync #(
  parameter int Width = 8,
  parameter int Depth = 2,
  localparam int CntW = $clog2(Depth + 1),
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_tvalid,
  input  logic [Width-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [Width-1:0] m_tdata,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             push;
  logic             pop;

  assign m_tvalid = (count != '0);
  assign m_tdata  = mem[rd_ptr];
  assign pop      = m_tvalid && m_tready;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign push     = s_tvalid && ((count < CntW'(Depth)) || pop);

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count alone
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; only count/pointers define validity
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end

endmodule

// File: rtl/tl_sram_bridge.sv
// rtl/tl_sram_bridge.sv - TL-UL device to single-port SRAM bridge with response FIFO
module tl_sram_bridge
  import tlul_pkg::*;
#(
  parameter int SramAw   = 12,
  parameter int RspDepth = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tl_h2d_t           tl_i,
  output tl_d2h_t           tl_o,
  output logic              req_o,
  output logic              we_o,
  output logic [SramAw-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic [31:0]       wmask_o,
  input  logic [31:0]       rdata_i
);

  localparam int CntW = $clog2(RspDepth + 1);

  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   occupancy;
  logic            a_ready;
  logic            accept;
  logic            a_err;
  logic            op_ok;
  logic            align_ok;
  logic            mask_ok;
  logic [3:0]      lanes;

  logic            inflight_q;
  logic [2:0]      inf_op_q;
  logic [1:0]      inf_size_q;
  logic [SrcW-1:0] inf_source_q;
  logic            inf_err_q;

  tl_rsp_t         push_entry;
  tl_rsp_t         head;
  logic            fifo_valid;
  logic [$bits(tl_rsp_t)-1:0] fifo_head;

  logic            unused_bits;
  assign unused_bits = ^{tl_i.a_param, tl_i.a_address[31:SramAw+2]};

  // The in-flight request will need a FIFO slot next cycle, so it counts as occupied
  assign occupancy = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q};
  assign a_ready   = !rst_i && (occupancy < (CntW + 1)'(RspDepth));
  assign accept    = tl_i.a_valid && a_ready;
  assign lanes     = size_mask(tl_i.a_size, tl_i.a_address[1:0]);

  // Request legality: opcode, size/alignment, and full-lane mask for PutFullData
  always_comb begin
    op_ok = (tl_i.a_opcode == Get) || (tl_i.a_opcode == PutFullData) ||
            (tl_i.a_opcode == PutPartialData);
    case (tl_i.a_size)
      2'd0:    align_ok = 1'b1;
      2'd1:    align_ok = !tl_i.a_address[0];
      2'd2:    align_ok = (tl_i.a_address[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
    mask_ok = (tl_i.a_opcode != PutFullData) || ((tl_i.a_mask & lanes) == lanes);
    a_err   = !(op_ok && align_ok && mask_ok);
  end

  // SRAM side: strobe only for legal accepts; everything quiet while in reset
  always_comb begin
    req_o   = accept && !a_err;
    we_o    = req_o && (tl_i.a_opcode != Get);
    addr_o  = '0;
    wdata_o = '0;
    wmask_o = '0;
    if (!rst_i) begin
      addr_o  = tl_i.a_address[SramAw+1:2];
      wdata_o = tl_i.a_data;
      for (int b = 0; b < 4; b++) wmask_o[8*b +: 8] = {8{tl_i.a_mask[b]}};
    end
  end

  // One-entry in-flight stage waiting for the SRAM read data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= accept;
    end
    if (accept) begin
      inf_op_q     <= tl_i.a_opcode;
      inf_size_q   <= tl_i.a_size;
      inf_source_q <= tl_i.a_source;
      inf_err_q    <= a_err;
    end
  end

  // Build the response entry pushed the cycle after acceptance
  always_comb begin
    push_entry        = '0;
    push_entry.size   = inf_size_q;
    push_entry.source = inf_source_q;
    push_entry.error  = inf_err_q;
    if ((inf_op_q == Get) && !inf_err_q) begin
      push_entry.opcode = AccessAckData;
      push_entry.data   = rdata_i;
    end else begin
      push_entry.opcode = AccessAck;
      push_entry.data   = '0;
    end
  end

  fifo_sync #(
    .Width ($bits(tl_rsp_t)),
    .Depth (RspDepth)
  ) u_rsp_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .s_tvalid (inflight_q),
    .s_tdata  (push_entry),
    .m_tvalid (fifo_valid),
    .m_tready (tl_i.d_ready),
    .m_tdata  (fifo_head),
    .count    (fifo_count)
  );

  assign head = fifo_head;

  // D channel straight from the FIFO head; forced to zero during reset
  always_comb begin
    tl_o = '0;
    if (!rst_i) begin
      tl_o.a_ready  = a_ready;
      tl_o.d_valid  = fifo_valid;
      tl_o.d_opcode = head.opcode;
      tl_o.d_size   = head.size;
      tl_o.d_source = head.source;
      tl_o.d_error  = head.error;
      tl_o.d_data   = head.data;
    end
  end

endmodule
